cskip_a8: RTL and testbench
===========================

Name: cskip_a8

Overview:
- 8-bit unsigned carry-skip adder with registered outputs; no carry-in.
- Two 4-bit ripple-carry blocks, each with a block-propagate skip mux, form the combinational core. The sum and carry-out are captured on the clock edge.
- Used as a low-area adder leaf inside the arithmetic datapath, where a one-cycle registered result is acceptable.

Parameters:
- None. Width is fixed at 8 bits and skip-block size is fixed at 4 bits.

Ports:
- clk  input  1  system clock; all state updates on the rising edge
- rst_n  input  1  synchronous active-low reset, sampled on the rising edge of clk
- in_valid  input  1  qualifies a and b this cycle
- a  input  8  addend A, unsigned
- b  input  8  addend B, unsigned
- sum  output  8  registered low 8 bits of a+b
- cout  output  1  registered carry-out, bit 8 of a+b
- out_valid  output  1  high for one cycle when sum/cout hold a new result

Behaviour:
- Interface: one clock; reset is synchronous and active-low.
- Reset: when rst_n=0 at a rising edge, sum=8'h00, cout=0 and out_valid=0. Reset overrides in_valid. Any operation in flight is discarded. There is no asynchronous path.
- Core, purely combinational:
  - Per bit: p[i]=a[i]^b[i], g[i]=a[i]&b[i].
  - Block 0 (bits 3:0): full-adder ripple with carry-in 0. Its block carry-out c4 is the ripple carry.
  - Block 1 (bits 7:4): full-adder ripple with carry-in c4.
  - Block 1 carry-out: cout_c = (&p[7:4]) ? c4 : ripple carry out of bit 7.
  - Block 0 also has a skip mux, with its skip input tied to the constant 0 carry-in: c4 = (&p[3:0]) ? 1'b0 : ripple carry out of bit 3.
  - sum_c[i] = p[i] ^ c[i].
- Functional result must equal {cout_c, sum_c} = a + b (9-bit, unsigned) for all 65536 input pairs. The skip structure changes timing only, never the value.
- Register stage, at each rising edge with rst_n=1:
  - If in_valid=1: sum<=sum_c, cout<=cout_c, out_valid<=1.
  - If in_valid=0: sum and cout hold their previous values; out_valid<=0.
- Latency and throughput:
  - Inputs applied with in_valid in cycle N appear on sum/cout/out_valid after edge N+1, a latency of 1 cycle.
  - A new operation is accepted every cycle. There is no backpressure.
- Boundaries:
  - 8'hFF+8'hFF gives sum=8'hFE, cout=1.
  - 8'h00+8'h00 gives sum=8'h00, cout=0.
  - Overflow wraps modulo 256, with cout as bit 8.
- Deassertion of rst_n with in_valid=1 in the same cycle: the first edge with rst_n=1 captures that operand pair normally.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with in_valid=1, a=8'hFF, b=8'hFF -> sum=8'h00, cout=0, out_valid=0 throughout. Release rst_n -> next edge gives sum=8'hFE, cout=1, out_valid=1.
- Directed sequence, one pair per cycle with in_valid=1; results appear one cycle later, out_valid stays high:
  - A0+A0 -> sum 40, cout 1
  - 58+F4 -> sum 4C, cout 1
  - 3D+0F -> sum 4C, cout 0
  - CA+C8 -> sum 92, cout 1
  - A6+F4 -> sum 9A, cout 1
  - F3+CC -> sum BF, cout 1
  - F3+57 -> sum 4A, cout 1
- Skip paths:
  - a=8'h0F, b=8'hF1 (block 1 full propagate, c4=1) -> sum 00, cout 1.
  - a=8'h0F, b=8'h00 (block 0 full propagate, cin 0) -> sum 0F, cout 0.
  - a=8'hF0, b=8'h0F -> sum FF, cout 0.
- Hold: apply 12+34 with in_valid=1, then 2 cycles with in_valid=0 and a=8'hFF, b=8'h01 -> sum stays 46, cout 0, out_valid pulses for 1 cycle then is 0.
- Exhaustive: all 65536 (a,b) pairs back-to-back with in_valid=1 -> each {cout,sum} equals the 9-bit reference a+b one cycle later. No mismatches are permitted.

Source files
------------

// File: rtl/cskip_a8_if.sv
// rtl/cskip_a8_if.sv - operand/result bundle for the 8-bit carry-skip adder
interface cskip_a8_if;
  logic       in_valid;
  logic [7:0] a;
  logic [7:0] b;
  logic [7:0] sum;
  logic       cout;
  logic       out_valid;

  // Producer of operands, consumer of results
  modport master (
    output in_valid, a, b,
    input  sum, cout, out_valid
  );

  // The adder itself
  modport slave (
    input  in_valid, a, b,
    output sum, cout, out_valid
  );
endinterface

// File: rtl/cskip_a8.sv
// rtl/cskip_a8.sv - 8-bit carry-skip adder, two 4-bit skip blocks, registered result
module cskip_a8 (
  input  logic        clk,
  input  logic        rst_n,
  cskip_a8_if.slave   bus
);

  logic [7:0] p;
  logic [7:0] g;
  logic [8:0] c;
  logic [7:0] sum_c;
  logic       cout_c;

  assign p = bus.a ^ bus.b;
  assign g = bus.a & bus.b;

  // Two ripple blocks; each block carry-out goes through a propagate skip mux.
  // Block 0's skip input is the constant-zero carry-in, so the mux only
  // shortens the path and never changes the value.
  always_comb begin
    logic [8:0] r;
    r    = '0;
    c    = '0;
    r[0] = 1'b0;
    c[0] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      r[i+1] = g[i] | (p[i] & r[i]);
      c[i+1] = r[i+1];
    end
    c[4] = (&p[3:0]) ? 1'b0 : r[4];
    r[4] = c[4];
    for (int i = 4; i < 8; i++) begin
      r[i+1] = g[i] | (p[i] & r[i]);
      c[i+1] = r[i+1];
    end
    c[8]   = (&p[7:4]) ? c[4] : r[8];
    cout_c = c[8];
    sum_c  = p ^ c[7:0];
  end

  // Result register: capture on in_valid, hold otherwise; out_valid is a one-cycle flag
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus.sum       <= 8'h00;
      bus.cout      <= 1'b0;
      bus.out_valid <= 1'b0;
    end else if (bus.in_valid) begin
      bus.sum       <= sum_c;
      bus.cout      <= cout_c;
      bus.out_valid <= 1'b1;
    end else begin
      bus.out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cskip_a8.sv
// tb/tb_cskip_a8.sv - directed and exhaustive checks for cskip_a8
module tb_cskip_a8;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  cskip_a8_if bus ();

  cskip_a8 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts and reports
  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Apply one operand pair, advance one edge, sample just after it
  task automatic step(input logic v, input logic [7:0] a, input logic [7:0] b);
    bus.in_valid = v;
    bus.a        = a;
    bus.b        = b;
    @(posedge clk);
    #1;
  endtask

  // Compare the full registered result {out_valid, cout, sum}
  task automatic check_out(input string tag, input logic ov, input logic co, input logic [7:0] s);
    check(tag, {6'b0, bus.out_valid, bus.cout, bus.sum}, {6'b0, ov, co, s});
  endtask

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] s;
    logic       co;
  } vec_t;

  vec_t vecs [10] = '{
    '{8'hA0, 8'hA0, 8'h40, 1'b1},
    '{8'h58, 8'hF4, 8'h4C, 1'b1},
    '{8'h3D, 8'h0F, 8'h4C, 1'b0},
    '{8'hCA, 8'hC8, 8'h92, 1'b1},
    '{8'hA6, 8'hF4, 8'h9A, 1'b1},
    '{8'hF3, 8'hCC, 8'hBF, 1'b1},
    '{8'hF3, 8'h57, 8'h4A, 1'b1},
    '{8'h0F, 8'hF1, 8'h00, 1'b1},
    '{8'h0F, 8'h00, 8'h0F, 1'b0},
    '{8'hF0, 8'h0F, 8'hFF, 1'b0}
  };

  initial begin
    n_checks     = 0;
    n_fail       = 0;
    rst_n        = 1'b0;
    bus.in_valid = 1'b1;
    bus.a        = 8'hFF;
    bus.b        = 8'hFF;

    // Reset overrides in_valid
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 8'hFF, 8'hFF);
      check_out("reset", 1'b0, 1'b0, 8'h00);
    end

    // First edge out of reset captures the pending pair
    rst_n = 1'b1;
    step(1'b1, 8'hFF, 8'hFF);
    check_out("release_ff_ff", 1'b1, 1'b1, 8'hFE);

    step(1'b1, 8'h00, 8'h00);
    check_out("zero_zero", 1'b1, 1'b0, 8'h00);

    // Directed and skip-path vectors, back to back
    for (int i = 0; i < 10; i++) begin
      step(1'b1, vecs[i].a, vecs[i].b);
      check_out($sformatf("vec%0d", i), 1'b1, vecs[i].co, vecs[i].s);
    end

    // Hold behaviour
    step(1'b1, 8'h12, 8'h34);
    check_out("hold_load", 1'b1, 1'b0, 8'h46);
    for (int i = 0; i < 2; i++) begin
      step(1'b0, 8'hFF, 8'h01);
      check_out($sformatf("hold%0d", i), 1'b0, 1'b0, 8'h46);
    end

    // Exhaustive sweep against the 9-bit reference sum
    for (int i = 0; i < 65536; i++) begin
      logic [7:0] ea;
      logic [7:0] eb;
      logic [8:0] ref_sum;
      ea      = i[15:8];
      eb      = i[7:0];
      ref_sum = {1'b0, ea} + {1'b0, eb};
      step(1'b1, ea, eb);
      check_out($sformatf("exh_%h_%h", ea, eb), 1'b1, ref_sum[8], ref_sum[7:0]);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
